// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the BCD countdown control stage: state encodings, enable constants, default divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package countdown_ctrl_pkg;

    // FSM state encodings
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    // One decrement per second at a 100 MHz system clock
    localparam int unsigned DEF_TICK_DIV = 100_000_000;

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Modulo-DIV prescaler: terminal strobe at DIV-1, half-period strobe at DIV/2-1 and DIV-1.
// Latency: strobes are combinational decodes of the registered count.
// Backpressure: none; 'hold' freezes the count for one cycle, 'clr' overrides everything.
module countdown_ctrl_tick_gen
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    input  logic hold,
    output logic terminal,
    output logic half
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign terminal = (cnt == W'(DIV - 1));
    assign half     = (cnt == W'(DIV / 2 - 1)) || terminal;

    // Count while running and not held; wrap to 0 after the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !hold) begin
            cnt <= terminal ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown control: 1 Hz tick prescaler, IDLE/RUN/PAUSE/DONE FSM, chain reload stretcher, expiry alarm (TIMER_ALARM_EN).
// Latency: all outputs registered, 1 cycle after the qualifying pulse or terminal count.
// Backpressure: none; button pulses act in the cycle they arrive, pausing withholds tick rather than cnt_en.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_pause,
    input  logic clear,
    input  logic all_zero,
    output logic tick,
    output logic cnt_en,
    output logic cnt_rst_n,
    output logic running,
    output logic done,
    output logic alarm
);

    state_t state;
    state_t nxt;
    logic   tick_nxt;
    logic   pre_term;
    logic   unused_pre_half;
    logic   rld_pend;

    // Prescaler: advances only in RUN; a start_pause in RUN freezes it so the
    // partial second survives the pause. Held at 0 throughout IDLE.
    countdown_ctrl_tick_gen #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state == RUN),
        .clr      (clear || (state == IDLE)),
        .hold     (start_pause),
        .terminal (pre_term),
        .half     (unused_pre_half)
    );

    // Next-state and tick decision; clear has top priority, then pause, then terminal count
    always_comb begin
        nxt      = state;
        tick_nxt = 1'b0;
        if (clear) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pause && !all_zero) begin
                        nxt = RUN;
                    end
                end
                RUN: begin
                    if (start_pause) begin
                        nxt = PAUSE;
                    end else if (pre_term) begin
                        if (all_zero) begin
                            nxt = DONE;
                        end else begin
                            tick_nxt = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start_pause) begin
                        nxt = RUN;
                    end
                end
                DONE: begin
                    nxt = DONE;
                end
                default: begin
                    nxt = IDLE;
                end
            endcase
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tick    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            cnt_en  <= ENABLED;
        end else begin
            state   <= nxt;
            tick    <= tick_nxt;
            running <= (nxt == RUN);
            done    <= (nxt == DONE);
            cnt_en  <= (nxt == DONE) ? DISABLED : ENABLED;
        end
    end

    // Reload stretcher: clear holds the chain reload low for exactly two cycles;
    // out of reset the reload releases on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rst_n <= 1'b0;
            rld_pend  <= 1'b0;
        end else if (clear) begin
            cnt_rst_n <= 1'b0;
            rld_pend  <= 1'b1;
        end else if (rld_pend) begin
            cnt_rst_n <= 1'b0;
            rld_pend  <= 1'b0;
        end else begin
            cnt_rst_n <= 1'b1;
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int SEC_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    logic             done_entry;
    logic             alarm_on;
    logic             blink_term;
    logic             blink_half;
    logic [SEC_W-1:0] sec_cnt;

    assign done_entry = (nxt == DONE) && (state != DONE);

    // Blink timebase restarts on DONE entry, runs only while the alarm is active
    countdown_ctrl_tick_gen #(
        .DIV (TICK_DIV)
    ) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      ((state == DONE) && alarm_on),
        .clr      (clear || done_entry),
        .hold     (1'b0),
        .terminal (blink_term),
        .half     (blink_half)
    );

    // Alarm: start high on expiry, toggle every half period, stop after ALARM_SEC periods
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm    <= 1'b0;
            alarm_on <= 1'b0;
            sec_cnt  <= '0;
        end else if (clear) begin
            alarm    <= 1'b0;
            alarm_on <= 1'b0;
            sec_cnt  <= '0;
        end else if (done_entry) begin
            alarm    <= 1'b1;
            alarm_on <= 1'b1;
            sec_cnt  <= '0;
        end else if ((state == DONE) && alarm_on && blink_half) begin
            if (blink_term && (sec_cnt == SEC_W'(ALARM_SEC - 1))) begin
                alarm    <= 1'b0;
                alarm_on <= 1'b0;
            end else begin
                alarm <= ~alarm;
                if (blink_term) begin
                    sec_cnt <= sec_cnt + SEC_W'(1);
                end
            end
        end
    end
`else
    localparam int unsigned unused_alarm_sec = ALARM_SEC;

    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start_pause;
    logic clear;
    logic all_zero;
    logic tick;
    logic cnt_en;
    logic cnt_rst_n;
    logic running;
    logic done;
    logic alarm;

    int n_cmp = 0;
    int n_err = 0;

`ifdef TIMER_ALARM_EN
    localparam logic ALM = 1'b1;
`else
    localparam logic ALM = 1'b0;
`endif

    always #5 clk = ~clk;

    countdown_ctrl #(
        .TICK_DIV  (10),
        .ALARM_SEC (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_pause (start_pause),
        .clear       (clear),
        .all_zero    (all_zero),
        .tick        (tick),
        .cnt_en      (cnt_en),
        .cnt_rst_n   (cnt_rst_n),
        .running     (running),
        .done        (done),
        .alarm       (alarm)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sp();
        start_pause = 1'b1;
        step(1);
        start_pause = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    // vec = {tick, cnt_en, cnt_rst_n, running, done, alarm}
    task automatic test_reset();
        rst_n = 1'b0; start_pause = 1'b0; clear = 1'b0; all_zero = 1'b0;
        step(3);
        n_cmp++;
        if ({tick, cnt_en, cnt_rst_n, running, done, alarm} !== 6'b010000) begin
            n_err++;
            $display("FAIL reset_vals: got %b want 010000", {tick, cnt_en, cnt_rst_n, running, done, alarm});
        end
        rst_n = 1'b1;
        step(1);
        n_cmp++;
        if ({tick, cnt_en, cnt_rst_n, running, done, alarm} !== 6'b011000) begin
            n_err++;
            $display("FAIL reset_release: got %b want 011000", {tick, cnt_en, cnt_rst_n, running, done, alarm});
        end
    endtask

    task automatic test_run();
        all_zero = 1'b0;
        pulse_sp();
        n_cmp++;
        if ({tick, cnt_en, cnt_rst_n, running, done, alarm} !== 6'b011100) begin
            n_err++;
            $display("FAIL run_rise: got %b want 011100", {tick, cnt_en, cnt_rst_n, running, done, alarm});
        end
        for (int k = 1; k <= 30; k++) begin
            step(1);
            n_cmp++;
            if (tick !== ((k % 10) == 0)) begin
                n_err++;
                $display("FAIL run_tick cycle %0d: tick=%b want %b", k, tick, ((k % 10) == 0));
            end
        end
    endtask

    task automatic test_pause_resume();
        step(4);
        pulse_sp();
        n_cmp++;
        if ({tick, running} !== 2'b00) begin
            n_err++;
            $display("FAIL pause_enter: tick,running=%b want 00", {tick, running});
        end
        for (int k = 1; k <= 50; k++) begin
            step(1);
            n_cmp++;
            if ({tick, running} !== 2'b00) begin
                n_err++;
                $display("FAIL pause_hold cycle %0d: tick,running=%b want 00", k, {tick, running});
            end
        end
        pulse_sp();
        n_cmp++;
        if ({tick, running} !== 2'b01) begin
            n_err++;
            $display("FAIL resume_rise: tick,running=%b want 01", {tick, running});
        end
        for (int k = 1; k <= 10; k++) begin
            step(1);
            n_cmp++;
            if (tick !== (k == 6)) begin
                n_err++;
                $display("FAIL resume_tick cycle %0d: tick=%b want %b", k, tick, (k == 6));
            end
        end
    endtask

    task automatic test_terminal_pause();
        pulse_clr();
        step(3);
        all_zero = 1'b0;
        pulse_sp();
        step(9);
        pulse_sp();
        n_cmp++;
        if ({tick, running} !== 2'b00) begin
            n_err++;
            $display("FAIL term_pause: tick,running=%b want 00", {tick, running});
        end
        step(3);
        pulse_sp();
        n_cmp++;
        if ({tick, running} !== 2'b01) begin
            n_err++;
            $display("FAIL term_resume: tick,running=%b want 01", {tick, running});
        end
        step(1);
        n_cmp++;
        if (tick !== 1'b1) begin
            n_err++;
            $display("FAIL term_resume_tick: tick=%b want 1", tick);
        end
        step(1);
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL term_resume_width: tick=%b want 0", tick);
        end
    endtask

    task automatic test_expiry();
        logic expa;
        pulse_clr();
        step(3);
        all_zero = 1'b0;
        pulse_sp();
        step(5);
        all_zero = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            step(1);
            n_cmp++;
            if ({tick, done, cnt_en} !== 3'b001) begin
                n_err++;
                $display("FAIL expiry_pre cycle %0d: tick,done,cnt_en=%b want 001", i, {tick, done, cnt_en});
            end
        end
        step(1);
        n_cmp++;
        if ({tick, cnt_en, running, done, alarm} !== {4'b0001, ALM}) begin
            n_err++;
            $display("FAIL expiry_done: tick,cnt_en,running,done,alarm=%b want %b",
                     {tick, cnt_en, running, done, alarm}, {4'b0001, ALM});
        end
        for (int j = 1; j <= 24; j++) begin
            step(1);
            expa = ALM && ((j < 5) || ((j >= 10) && (j < 15)));
            n_cmp++;
            if ({done, cnt_en, alarm} !== {2'b10, expa}) begin
                n_err++;
                $display("FAIL alarm_blink cycle %0d: done,cnt_en,alarm=%b want %b", j, {done, cnt_en, alarm}, {2'b10, expa});
            end
        end
        step(10);
        n_cmp++;
        if ({done, alarm} !== 2'b10) begin
            n_err++;
            $display("FAIL alarm_end: done,alarm=%b want 10", {done, alarm});
        end
        // start_pause is ignored in DONE
        pulse_sp();
        step(12);
        n_cmp++;
        if ({tick, running, done, cnt_en} !== 4'b0010) begin
            n_err++;
            $display("FAIL done_ignore_sp: tick,running,done,cnt_en=%b want 0010", {tick, running, done, cnt_en});
        end
    endtask

    task automatic test_clear_priority();
        pulse_clr();
        step(3);
        all_zero = 1'b0;
        pulse_sp();
        step(3);
        clear = 1'b1;
        start_pause = 1'b1;
        step(1);
        clear = 1'b0;
        start_pause = 1'b0;
        n_cmp++;
        if ({running, done, cnt_en, cnt_rst_n} !== 4'b0010) begin
            n_err++;
            $display("FAIL clear_pri_c0: running,done,cnt_en,cnt_rst_n=%b want 0010", {running, done, cnt_en, cnt_rst_n});
        end
        step(1);
        n_cmp++;
        if (cnt_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL clear_rld_c1: cnt_rst_n=%b want 0", cnt_rst_n);
        end
        step(1);
        n_cmp++;
        if ({running, cnt_rst_n} !== 2'b01) begin
            n_err++;
            $display("FAIL clear_rld_c2: running,cnt_rst_n=%b want 01", {running, cnt_rst_n});
        end
        // Full period from a cleared prescaler
        pulse_sp();
        for (int k = 1; k <= 10; k++) begin
            step(1);
            n_cmp++;
            if (tick !== (k == 10)) begin
                n_err++;
                $display("FAIL clear_restart_tick cycle %0d: tick=%b want %b", k, tick, (k == 10));
            end
        end
    endtask

    task automatic test_ignored_start_idle();
        pulse_clr();
        step(3);
        all_zero = 1'b1;
        pulse_sp();
        for (int k = 1; k <= 15; k++) begin
            step(1);
            n_cmp++;
            if ({tick, running, done} !== 3'b000) begin
                n_err++;
                $display("FAIL idle_ignore cycle %0d: tick,running,done=%b want 000", k, {tick, running, done});
            end
        end
        all_zero = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_sp();
        step(3);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tick, cnt_en, cnt_rst_n, running, done, alarm} !== 6'b010000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 010000", {tick, cnt_en, cnt_rst_n, running, done, alarm});
        end
        step(1);
        rst_n = 1'b1;
        step(1);
        n_cmp++;
        if ({cnt_rst_n, running} !== 2'b10) begin
            n_err++;
            $display("FAIL async_release: cnt_rst_n,running=%b want 10", {cnt_rst_n, running});
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_terminal_pause();
        test_expiry();
        test_clear_priority();
        test_ignored_start_idle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control stage for the BCD countdown timer. It sits directly upstream of the chained BCD down-counter digits. It divides the system clock into one-per-second decrement pulses for the least-significant digit, and runs a start/pause/done state machine from debounced button pulses. It also stops the chain at 00:00 instead of letting it wrap, and raises a blinking alarm when the count expires.

## Interface
- TICK_DIV, 100_000_000: clk cycles per decrement tick; must be an even value ≥ 4.
- ALARM_SEC, 5: number of ticks the alarm blinks after expiry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_pause  in  1  single-cycle debounced pulse; toggles run/pause.
- clear  in  1  single-cycle debounced pulse; reloads the chain and returns to IDLE.
- all_zero  in  1  high when every digit of the counter chain is 0.
- tick  out  1  one-cycle decrement pulse to the least-significant digit's decrease input.
- cnt_en  out  1  enable to every digit of the chain.
- cnt_rst_n  out  1  registered active-low reload for the chain's rst_n.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- alarm  out  1  blink output.

## Operation
- States:
  - IDLE: after reset or clear.
  - RUN
  - PAUSE
  - DONE
- Transitions, in priority order:
  - clear in any state → IDLE. It clears the prescaler and alarm counters and drives cnt_rst_n low for exactly 2 cycles.
  - IDLE + start_pause + !all_zero → RUN, with the prescaler cleared to 0. IDLE + start_pause + all_zero → stay in IDLE; the pulse is ignored.
  - RUN + start_pause → PAUSE. The prescaler holds its value, so the partial second is preserved.
  - RUN + prescaler==TICK_DIV-1 + all_zero → DONE, and no tick is issued. This prevents wrap to the limit.
  - RUN + prescaler==TICK_DIV-1 + !all_zero → issue tick, prescaler wraps to 0.
  - PAUSE + start_pause → RUN, with the prescaler resuming from its held value.
  - DONE: start_pause is ignored. The block stays in DONE until clear.
- Prescaler: width is clog2(TICK_DIV). It increments only in RUN.
- cnt_en: high in IDLE, RUN and PAUSE; low in DONE, which forces the digits to 0. The chain is never paused via cnt_en; pausing works by withholding tick.
- Alarm: active on entry to DONE. alarm toggles every TICK_DIV/2 cycles, starting high, for ALARM_SEC×TICK_DIV cycles. After that alarm is 0 while the block stays in DONE.

## Timing
- Reset values: tick=0, cnt_en=1, cnt_rst_n=0, running=0, done=0, alarm=0, state=IDLE, prescaler=0.
- cnt_rst_n rises on the first clk edge after rst_n deasserts.
- All outputs are registered. running and done change 1 cycle after the qualifying input pulse or terminal count.
- tick is high for exactly 1 cycle. The period is exactly TICK_DIV cycles of RUN time. The first tick occurs TICK_DIV cycles after running rises from IDLE.
- start_pause in the same cycle as a terminal count in RUN → PAUSE with no tick. The prescaler holds at TICK_DIV-1, so tick fires 1 cycle after running re-rises.
- all_zero is sampled only at a terminal count, and it must be stable by then. It changes 1 cycle after tick, which is well before the next terminal.
- Asserting rst_n mid-operation returns all state asynchronously to the reset values.

## Configuration
- TIMER_ALARM_EN defined: the alarm counters and blink logic are compiled in, as described above.
- TIMER_ALARM_EN undefined: alarm is tied to 0 and the alarm counters are removed. DONE behaviour is otherwise identical.

## Structure
- Shared include timer_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - ENABLED/DISABLED constants;
  - the default TICK_DIV.
- One sub-module, tick_gen: the prescaler with inputs run, clr and load-hold, and outputs terminal and half-period strobe. It is reused by the alarm blink.
- The FSM, the reload stretcher and output registers stay in countdown_ctrl.

## Test plan
All scenarios use TICK_DIV=10 and ALARM_SEC=2.
- Reset: hold rst_n low → all outputs at reset values. Release rst_n → cnt_rst_n=1 next cycle, state IDLE.
- Run: start_pause with all_zero=0 → running=1. tick pulses at cycles 10, 20, 30 after running rises, each 1 cycle wide.
- Pause/resume: pause 4 cycles into a period, hold 50 cycles, resume → no tick during pause. The first tick comes 6 cycles after running re-rises.
- Expiry: raise all_zero before a terminal count → no tick, done=1, cnt_en=0. alarm is high 5 cycles, low 5, high 5, low 5, then 0; done stays 1.
- Clear priority: clear together with start_pause in RUN → IDLE, running=0, cnt_rst_n low for exactly 2 cycles, prescaler 0.
- Ignored start: start_pause in IDLE with all_zero=1 → stays IDLE, no tick. start_pause in DONE → no change.
